d_reg_pipe: RTL and testbench



---
 rtl/d_reg_pipe_pkg.sv | 16 +
 rtl/d_ff_stage.sv | 52 +++++
 rtl/d_reg_pipe.sv | 106 ++++++++++
 tb/tb_d_reg_pipe.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_reg_pipe_pkg.sv
// rtl/d_reg_pipe_pkg.sv - shared defaults and helpers for the d_reg_pipe delay line
//
// Purpose: default WIDTH/DEPTH/RST_VAL values and the occupancy-counter width
//          function used by d_reg_pipe and d_ff_stage.
package d_reg_pipe_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam logic [DEF_WIDTH-1:0] DEF_RST_VAL = '0;

    // Width needed to hold an occupancy value in the range 0..depth.
    function automatic int CNT_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/d_ff_stage.sv
// rtl/d_ff_stage.sv - one stage of the d_reg_pipe delay line (data flop + valid flop)
//
// Purpose: WIDTH-bit data register plus a valid bit, with synchronous
//          active-high reset, advance enable and a valid-only clear.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (data -> RST_VAL, valid -> 0)
//   en       in   1 = capture d/d_valid, 0 = hold
//   clr      in   clears the valid bit only; data still follows en
//   d        in   WIDTH-bit data from the previous stage
//   d_valid  in   valid bit from the previous stage
//   q        out  registered data
//   q_valid  out  registered valid
module d_ff_stage
    import d_reg_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;

    always_comb begin
        data_d = en ? d : data_q;
        // clr wins over en for the valid bit; the data path is never gated.
        vld_d  = clr ? 1'b0 : (en ? d_valid : vld_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= RST_VAL;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q       = data_q;
    assign q_valid = vld_q;

endmodule

// File: rtl/d_reg_pipe.sv
// rtl/d_reg_pipe.sv - stallable, flushable DEPTH-stage delay line with valid bits and occupancy count
//
// Purpose: delays a WIDTH-bit word by DEPTH advancing cycles, carrying a valid
//          bit per stage and tracking how many stages hold valid data.
//          Edge priority: rst > flush > en.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   en         in   1 = all stages shift by one, 0 = all state holds
//   d          in   input data, captured into stage 0 when en=1
//   d_valid    in   qualifies d
//   flush      in   clears all valid bits and count; data still shifts if en=1
//   q          out  data of the last stage
//   q_valid    out  valid bit of the last stage
//   count      out  number of stages holding valid data
//   taps       out  (D_REG_PIPE_TAPS_EN only) all stage data, stage i at [i*WIDTH +: WIDTH]
//   tap_valid  out  (D_REG_PIPE_TAPS_EN only) all stage valid bits
// Configuration macro: D_REG_PIPE_TAPS_EN
module d_reg_pipe
    import d_reg_pipe_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               DEPTH   = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DEF_RST_VAL)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [WIDTH-1:0]          d,
    input  logic                      d_valid,
    input  logic                      flush,
    output logic [WIDTH-1:0]          q,
    output logic                      q_valid,
    output logic [CNT_W(DEPTH)-1:0]   count
`ifdef D_REG_PIPE_TAPS_EN
    ,
    output logic [WIDTH*DEPTH-1:0]    taps,
    output logic [DEPTH-1:0]          tap_valid
`endif
);

    localparam int CW = CNT_W(DEPTH);

    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [WIDTH-1:0] data_w  [DEPTH];
    logic [DEPTH-1:0] stage_v;
    logic [DEPTH-1:0] vld_w;

    logic [CW-1:0]    count_q, count_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign stage_d[i] = d;
            assign stage_v[i] = d_valid;
        end else begin : g_body
            assign stage_d[i] = data_w[i-1];
            assign stage_v[i] = vld_w[i-1];
        end

        d_ff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .clr     (flush),
            .d       (stage_d[i]),
            .d_valid (stage_v[i]),
            .q       (data_w[i]),
            .q_valid (vld_w[i])
        );
    end

    // Incremental occupancy: one word may enter and one may leave per advance.
    // The leaving word is whatever was valid in the last stage before the edge,
    // so the result stays equal to popcount of the valid bits and never wraps.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CW'(d_valid) - CW'(vld_w[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q       = data_w[DEPTH-1];
    assign q_valid = vld_w[DEPTH-1];
    assign count   = count_q;

`ifdef D_REG_PIPE_TAPS_EN
    for (genvar t = 0; t < DEPTH; t++) begin : g_taps
        assign taps[t*WIDTH +: WIDTH] = data_w[t];
    end
    assign tap_valid = vld_w;
`endif

endmodule

// File: tb/tb_d_reg_pipe.sv
// tb/tb_d_reg_pipe.sv - self-checking bench for d_reg_pipe (WIDTH=8, DEPTH=4, RST_VAL=0)
module tb_d_reg_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst, en, d_valid, flush;
    logic [WIDTH-1:0] d, q;
    logic             q_valid;
    logic [CW-1:0]    count;
`ifdef D_REG_PIPE_TAPS_EN
    logic [WIDTH*DEPTH-1:0] taps;
    logic [DEPTH-1:0]       tap_valid;
`endif

    always #5 clk = ~clk;

    d_reg_pipe #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .RST_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .d         (d),
        .d_valid   (d_valid),
        .flush     (flush),
        .q         (q),
        .q_valid   (q_valid),
        .count     (count)
`ifdef D_REG_PIPE_TAPS_EN
        ,
        .taps      (taps),
        .tap_valid (tap_valid)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: behavioural shift register, count derived by popcount.
    logic [WIDTH-1:0] m_data [DEPTH];
    logic             m_vld  [DEPTH];
    logic [CW-1:0]    m_count;
    bit               last_adv;
    bit               model_live = 1'b0;
    logic [WIDTH-1:0] sb [$];

    task automatic adv(input logic e, input logic [WIDTH-1:0] dd, input logic dv,
                       input logic fl, input logic rs);
        int pc;
        rst = rs; en = e; d = dd; d_valid = dv; flush = fl;
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_data[i] = 8'h00;
                m_vld[i]  = 1'b0;
            end
            sb.delete();
            last_adv   = 1'b0;
            model_live = 1'b1;
        end else begin
            if (e) begin
                for (int i = DEPTH - 1; i > 0; i--) begin
                    m_data[i] = m_data[i-1];
                    m_vld[i]  = m_vld[i-1];
                end
                m_data[0] = dd;
                m_vld[0]  = dv;
            end
            if (fl) begin
                for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
                sb.delete();
            end else if (e && dv) begin
                sb.push_back(dd);
            end
            last_adv = e && !fl;
        end
        pc = 0;
        for (int i = 0; i < DEPTH; i++) pc += int'(m_vld[i]);
        m_count = CW'(pc);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++)
            adv(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        adv(1'b0, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
        n_cmp++; if (q !== 8'h00)
            begin n_bad++; $display("FAIL reset_q: got %h want 00", q); end
        n_cmp++; if (q_valid !== 1'b0)
            begin n_bad++; $display("FAIL reset_q_valid: got %b want 0", q_valid); end
        n_cmp++; if (count !== '0)
            begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] exp_q;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) adv(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
            else        adv(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
            n_cmp++; if (q_valid !== (k == 3))
                begin n_bad++; $display("FAIL single_q_valid k=%0d: got %b want %b", k, q_valid, k == 3); end
            n_cmp++; if (count !== CW'((k <= 3) ? 1 : 0))
                begin n_bad++; $display("FAIL single_count k=%0d: got %0d want %0d", k, count, (k <= 3) ? 1 : 0); end
            if (q_valid && last_adv) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL single_sb_empty k=%0d: got q=%h want no word", k, q);
                end else begin
                    exp_q = sb.pop_front();
                    if (q !== exp_q) begin n_bad++; $display("FAIL single_q k=%0d: got %h want %h", k, q, exp_q); end
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] hq;
        logic             hv;
        logic [CW-1:0]    hc;
        logic [WIDTH-1:0] exp_q;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)                adv(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
            else if (k >= 2 && k <= 4) adv(1'b0, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
            else                       adv(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
            if (k == 1) begin hq = q; hv = q_valid; hc = count; end
            if (k >= 2 && k <= 4) begin
                n_cmp++; if (q !== hq || q_valid !== hv || count !== hc) begin
                    n_bad++;
                    $display("FAIL stall_hold k=%0d: got q=%h v=%b c=%0d want q=%h v=%b c=%0d",
                             k, q, q_valid, count, hq, hv, hc);
                end
            end
            n_cmp++; if (q_valid !== (k == 6))
                begin n_bad++; $display("FAIL stall_q_valid k=%0d: got %b want %b", k, q_valid, k == 6); end
            n_cmp++; if (count !== CW'((k <= 6) ? 1 : 0))
                begin n_bad++; $display("FAIL stall_count k=%0d: got %0d want %0d", k, count, (k <= 6) ? 1 : 0); end
            if (q_valid && last_adv) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL stall_sb_empty k=%0d: got q=%h want no word", k, q);
                end else begin
                    exp_q = sb.pop_front();
                    if (q !== exp_q) begin n_bad++; $display("FAIL stall_q k=%0d: got %h want %h", k, q, exp_q); end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int               popped = 0;
        logic [WIDTH-1:0] exp_q;
        for (int k = 0; k < 14; k++) begin
            if (k < 8) adv(1'b1, 8'(k + 1), 1'b1, 1'b0, 1'b0);
            else       adv(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
            n_cmp++; if (count !== m_count)
                begin n_bad++; $display("FAIL b2b_count k=%0d: got %0d want %0d", k, count, m_count); end
            n_cmp++; if (q_valid !== m_vld[DEPTH-1])
                begin n_bad++; $display("FAIL b2b_q_valid k=%0d: got %b want %b", k, q_valid, m_vld[DEPTH-1]); end
            if (k >= 3 && k < 8) begin
                n_cmp++; if (count !== CW'(4))
                    begin n_bad++; $display("FAIL b2b_full k=%0d: got %0d want 4", k, count); end
            end
            if (q_valid && last_adv) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL b2b_sb_empty k=%0d: got q=%h want no word", k, q);
                end else begin
                    exp_q = sb.pop_front();
                    popped++;
                    if (q !== exp_q) begin n_bad++; $display("FAIL b2b_q k=%0d: got %h want %h", k, q, exp_q); end
                end
            end
        end
        n_cmp++; if (popped != 8 || sb.size() != 0)
            begin n_bad++; $display("FAIL b2b_total: got %0d words (%0d left) want 8 (0 left)", popped, sb.size()); end
    endtask

    task automatic test_flush();
        adv(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
        adv(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
        adv(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        adv(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (count !== '0)
            begin n_bad++; $display("FAIL flush_count: got %0d want 0", count); end
        n_cmp++; if (q_valid !== 1'b0)
            begin n_bad++; $display("FAIL flush_q_valid: got %b want 0", q_valid); end
        n_cmp++; if (q !== 8'h11)
            begin n_bad++; $display("FAIL flush_q_shift: got %h want 11", q); end
        for (int k = 0; k < 3; k++) begin
            adv(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
            n_cmp++; if (q !== m_data[DEPTH-1] || q_valid !== 1'b0 || count !== '0) begin
                n_bad++;
                $display("FAIL flush_after k=%0d: got q=%h v=%b c=%0d want q=%h v=0 c=0",
                         k, q, q_valid, count, m_data[DEPTH-1]);
            end
        end
        // Flush while stalled: valids clear, data holds.
        adv(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        adv(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        adv(1'b0, 8'h99, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (q !== m_data[DEPTH-1] || q_valid !== 1'b0 || count !== '0) begin
            n_bad++;
            $display("FAIL flush_stalled: got q=%h v=%b c=%0d want q=%h v=0 c=0",
                     q, q_valid, count, m_data[DEPTH-1]);
        end
    endtask

    task automatic test_mid_reset();
        logic [WIDTH-1:0] exp_q;
        adv(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        adv(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0);
        adv(1'b1, 8'hCC, 1'b1, 1'b1, 1'b1);
        n_cmp++; if (q !== 8'h00 || q_valid !== 1'b0 || count !== '0)
            begin n_bad++; $display("FAIL midrst_state: got q=%h v=%b c=%0d want q=00 v=0 c=0", q, q_valid, count); end
        for (int k = 0; k < 6; k++) begin
            if (k == 0) adv(1'b1, 8'hDD, 1'b1, 1'b0, 1'b0);
            else        adv(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
            n_cmp++; if (q_valid !== (k == DEPTH - 1))
                begin n_bad++; $display("FAIL midrst_latency k=%0d: got %b want %b", k, q_valid, k == DEPTH - 1); end
            if (q_valid && last_adv) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("FAIL midrst_sb_empty k=%0d: got q=%h want no word", k, q);
                end else begin
                    exp_q = sb.pop_front();
                    if (q !== exp_q) begin n_bad++; $display("FAIL midrst_q k=%0d: got %h want %h", k, q, exp_q); end
                end
            end
        end
    endtask

`ifdef D_REG_PIPE_TAPS_EN
    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < DEPTH; i++) begin
                n_cmp++;
                if (taps[i*WIDTH +: WIDTH] !== m_data[i] || tap_valid[i] !== m_vld[i]) begin
                    n_bad++;
                    $display("FAIL taps[%0d]: got d=%h v=%b want d=%h v=%b",
                             i, taps[i*WIDTH +: WIDTH], tap_valid[i], m_data[i], m_vld[i]);
                end
            end
        end
    end
`endif

    initial begin
        rst = 1'b1; en = 1'b0; d = '0; d_valid = 1'b0; flush = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
